// File: rtl/lb_uart_pkg.sv
// ============================================================================
// Module : lb_uart_pkg
// Brief  : Shared UART defaults and oversample helpers (LB_BAUD_FRAC_EN aware)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lb_uart_pkg;

    localparam int unsigned LB_PRESCALE_W = 20;
    localparam int unsigned LB_OVS        = 16;
    localparam int unsigned LB_FRAC_W     = 8;
    localparam int unsigned LB_OS_W       = $clog2(LB_OVS);
    localparam int unsigned LB_MID_PT     = LB_OVS / 2 - 1;

    function automatic int unsigned lb_os_width(input int unsigned ovs);
        return (ovs < 2) ? 1 : $clog2(ovs);
    endfunction

    // Oversample index of the bit-centre sample point.
    function automatic int unsigned lb_mid_point(input int unsigned ovs);
        return ovs / 2 - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lb_tick_prescaler.sv
// ============================================================================
// Module : lb_tick_prescaler
// Brief  : Run-time clk divider producing the raw oversample tick; with
//          LB_BAUD_FRAC_EN defined, a fractional accumulator stretches periods.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lb_tick_prescaler
    import lb_uart_pkg::*;
#(
    parameter int unsigned PRESCALE_W = LB_PRESCALE_W,
    parameter int unsigned FRAC_W     = LB_FRAC_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [FRAC_W-1:0]     frac,
    output logic                  wrap,
    output logic                  tick
);

`ifdef LB_BAUD_FRAC_EN
    localparam int unsigned c_CNT_W = PRESCALE_W + 1;
`else
    localparam int unsigned c_CNT_W = PRESCALE_W;
`endif

    logic [c_CNT_W-1:0]    r_cnt;
    logic [PRESCALE_W-1:0] r_prescale_q;
    logic                  r_fresh;
    logic                  r_tick;
    logic [PRESCALE_W-1:0] w_base;
    logic [c_CNT_W-1:0]    w_limit;

    // The first period after reset uses the live prescale, captured on that same edge.
    assign w_base = r_fresh ? prescale : r_prescale_q;

`ifdef LB_BAUD_FRAC_EN
    logic [FRAC_W-1:0] r_acc;
    logic              r_stretch;
    logic [FRAC_W:0]   w_acc_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, frac};
    assign w_limit   = {1'b0, w_base} + {{PRESCALE_W{1'b0}}, r_stretch};

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_acc     <= '0;
            r_stretch <= 1'b0;
        end else if (wrap) begin
            {r_stretch, r_acc} <= w_acc_sum;
        end
    end
`else
    logic w_unused_frac;

    assign w_unused_frac = ^frac;
    assign w_limit       = w_base;
`endif

    assign wrap = !reset && enable && !restart && (r_cnt == w_limit);
    assign tick = r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_prescale_q <= '0;
            r_fresh      <= 1'b1;
            r_tick       <= 1'b0;
        end else if (restart) begin
            r_cnt        <= '0;
            r_prescale_q <= prescale;
            r_fresh      <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_fresh <= 1'b0;
            if (r_fresh) begin
                r_prescale_q <= prescale;
            end
            if (wrap) begin
                r_cnt        <= '0;
                r_tick       <= 1'b1;
                r_prescale_q <= prescale;
            end else begin
                r_tick <= 1'b0;
                if (enable) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lb_baud_tick_gen.sv
// ============================================================================
// Module : lb_baud_tick_gen
// Brief  : Baud tick generator: prescaled oversample tick plus bit/mid-bit
//          strobes. Optional fractional period via LB_BAUD_FRAC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lb_baud_tick_gen
    import lb_uart_pkg::*;
#(
    parameter int unsigned PRESCALE_W = LB_PRESCALE_W,
    parameter int unsigned OVS        = LB_OVS,
    parameter int unsigned FRAC_W     = LB_FRAC_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          restart,
    input  logic [PRESCALE_W-1:0]         prescale,
    input  logic [FRAC_W-1:0]             frac,
    output logic                          tick,
    output logic                          bit_tick,
    output logic                          mid_tick,
    output logic [lb_os_width(OVS)-1:0]   os_phase
);

    localparam int unsigned     c_OS_W    = lb_os_width(OVS);
    localparam logic [c_OS_W-1:0] c_OS_LAST = c_OS_W'(OVS - 1);
    localparam logic [c_OS_W-1:0] c_OS_MID  = c_OS_W'(lb_mid_point(OVS));

    logic              w_wrap;
    logic [c_OS_W-1:0] r_os_cnt;
    logic              r_bit_tick;
    logic              r_mid_tick;

    lb_tick_prescaler #(
        .PRESCALE_W (PRESCALE_W),
        .FRAC_W     (FRAC_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .restart  (restart),
        .prescale (prescale),
        .frac     (frac),
        .wrap     (w_wrap),
        .tick     (tick)
    );

    // Strobes are evaluated against the pre-update count so they align with tick.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            r_os_cnt   <= '0;
            r_bit_tick <= 1'b0;
            r_mid_tick <= 1'b0;
        end else if (w_wrap) begin
            r_os_cnt   <= (r_os_cnt == c_OS_LAST) ? '0 : r_os_cnt + 1'b1;
            r_bit_tick <= (r_os_cnt == c_OS_LAST);
            r_mid_tick <= (r_os_cnt == c_OS_MID);
        end else begin
            r_bit_tick <= 1'b0;
            r_mid_tick <= 1'b0;
        end
    end

    assign bit_tick = r_bit_tick;
    assign mid_tick = r_mid_tick;
    assign os_phase = r_os_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lb_baud_tick_gen.sv
// ============================================================================
// Module : tb_lb_baud_tick_gen
// Brief  : Self-checking bench for lb_baud_tick_gen (LB_BAUD_FRAC_EN aware)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lb_baud_tick_gen;

    localparam int PW  = 10;
    localparam int OVS = 16;
    localparam int FW  = 8;
    localparam int OSW = $clog2(OVS);

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          restart;
    logic [PW-1:0] prescale;
    logic [FW-1:0] frac;
    logic          tick;
    logic          bit_tick;
    logic          mid_tick;
    logic [OSW-1:0] os_phase;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: remaining enabled cycles until the next tick, and ticks completed.
    int m_rem;
    bit m_valid;
    int m_ticks;
    int m_acc;
    bit e_tick, e_bit, e_mid;
    int e_phase;

    always #5 clk = ~clk;

    lb_baud_tick_gen #(
        .PRESCALE_W (PW),
        .OVS        (OVS),
        .FRAC_W     (FW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .restart  (restart),
        .prescale (prescale),
        .frac     (frac),
        .tick     (tick),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .os_phase (os_phase)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        e_tick = 0;
        e_bit  = 0;
        e_mid  = 0;
        if (reset) begin
            m_valid = 0;
            m_ticks = 0;
            m_acc   = 0;
        end else if (restart) begin
            m_valid = 1;
            m_rem   = int'(prescale) + 1;
            m_ticks = 0;
            m_acc   = 0;
        end else begin
            if (!m_valid) begin
                m_valid = 1;
                m_rem   = int'(prescale) + 1;
            end
            if (enable) begin
                m_rem--;
                if (m_rem == 0) begin
                    int carry;
                    carry = 0;
                    m_ticks++;
                    e_tick = 1;
                    e_bit  = (m_ticks % OVS) == 0;
                    e_mid  = (m_ticks % OVS) == OVS / 2;
`ifdef LB_BAUD_FRAC_EN
                    m_acc = m_acc + int'(frac);
                    carry = m_acc >> FW;
                    m_acc = m_acc % (1 << FW);
`endif
                    m_rem = int'(prescale) + 1 + carry;
                end
            end
        end
        e_phase = m_ticks % OVS;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("tick",     {31'b0, tick},     {31'b0, e_tick});
        chk("bit_tick", {31'b0, bit_tick}, {31'b0, e_bit});
        chk("mid_tick", {31'b0, mid_tick}, {31'b0, e_mid});
        chk("os_phase", 32'(os_phase),     32'(e_phase));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic gap(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (tick !== 1'b1 && n < 3000);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        cycle();
        restart = 1'b0;
    endtask

    initial begin
        int g, g2, g3;
        reset    = 1'b1;
        enable   = 1'b0;
        restart  = 1'b0;
        prescale = PW'(3);
        frac     = 8'h80;
        run(3);

        // Basic divide-by-4 with bit/mid strobes over several bits.
        reset  = 1'b0;
        enable = 1'b1;
        run(140);
        gap(g);
        chk("period_p3", g, 4);

        // Tick every cycle.
        prescale = '0;
        run(40);
        gap(g);
        chk("period_p0", g, 1);

        // Enable hold mid-period: two cycles remain after the hold.
        prescale = PW'(3);
        pulse_restart();
        run(2);
        enable = 1'b0;
        run(7);
        enable = 1'b1;
        gap(g);
        chk("enable_hold", g, 2);

        // Prescale change mid-period takes effect next period.
        pulse_restart();
        run(1);
        prescale = PW'(9);
        gap(g);
        chk("chg_cur", g, 3);
        gap(g);
        chk("chg_next", g, 10);

        // Restart coincident with wrap suppresses the tick.
        prescale = PW'(3);
        pulse_restart();
        run(3);
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        chk("restart_wins", {31'b0, tick}, 32'd0);
        gap(g);
        chk("after_restart", g, 4);

        // Fractional stretch: 4,4,5,... with frac=0x80, constant 4 otherwise.
        frac = 8'h80;
        pulse_restart();
        gap(g);
        gap(g2);
        gap(g3);
`ifdef LB_BAUD_FRAC_EN
        chk("frac_pair", g2 + g3, 9);
`else
        chk("frac_pair", g2 + g3, 8);
`endif
        chk("frac_first", g, 4);

        // Randomized traffic against the reference.
        for (int i = 0; i < 1500; i++) begin
            enable  = ($urandom % 8) != 0;
            restart = ($urandom % 50) == 0;
            reset   = ($urandom % 400) == 0;
            if (($urandom % 30) == 0) prescale = PW'($urandom % 6);
            if (($urandom % 40) == 0) frac = FW'($urandom);
            cycle();
        end
        reset   = 1'b0;
        restart = 1'b0;
        enable  = 1'b1;

        // All-ones prescale: period 2^PW.
        prescale = '1;
        pulse_restart();
        gap(g);
        chk("allones_latency", g, 1 << PW);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
